fp_execute_stage2: RTL and testbench

//  Second stage of the floating point/integer-multiply pipeline, fed directly by
//  fp_execute_stage1 and feeding fp_execute_stage3. Per lane it does three things:
//  - aligns the smaller-exponent significand, producing guard/round/sticky bits;
//  - applies the float-to-int truncate/left-shift;
//  - forms the full 64-bit product for FP and integer multiplies.
//  It also squashes instructions killed by a memory-pipeline rollback.

---
 rtl/fp_execute_stage2.sv | 163 ++++++++++++++++
 tb/tb_fp_execute_stage2.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_execute_stage2.sv
// Floating point / integer multiply pipeline, stage 2: significand alignment with
// guard/round/sticky, float-to-int shifting, full 64-bit products, rollback squash.

package fp_defines_pkg;
  localparam int NUM_VECTOR_LANES = 16;

  typedef logic [1:0] thread_idx_t;
  typedef logic [3:0] subcycle_t;

  typedef enum logic [1:0] {
    PIPE_MEM         = 2'd0,
    PIPE_INT_ARITH   = 2'd1,
    PIPE_FLOAT_ARITH = 2'd2
  } pipeline_sel_t;

  typedef enum logic [3:0] {
    OP_ADD_F   = 4'd0,
    OP_SUB_F   = 4'd1,
    OP_MUL_F   = 4'd2,
    OP_FTOI    = 4'd3,
    OP_ITOF    = 4'd4,
    OP_MULL_I  = 4'd5,
    OP_MULH_I  = 4'd6,
    OP_MULHU_I = 4'd7
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       has_dest;
    logic [4:0] dest_reg;
    logic       dest_is_vector;
  } decoded_instruction_t;
endpackage

module fp_execute_stage2
  import fp_defines_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_rollback_en,
  input  thread_idx_t                  wb_rollback_thread_idx,
  input  pipeline_sel_t                wb_rollback_pipeline,
  input  logic                         fx1_instruction_valid,
  input  decoded_instruction_t         fx1_instruction,
  input  logic [NUM_VECTOR_LANES-1:0]  fx1_mask_value,
  input  thread_idx_t                  fx1_thread_idx,
  input  subcycle_t                    fx1_subcycle,
  input  logic [NUM_VECTOR_LANES-1:0]  fx1_result_is_inf,
  input  logic [NUM_VECTOR_LANES-1:0]  fx1_result_is_nan,
  input  logic [31:0]                  fx1_significand_le [NUM_VECTOR_LANES],
  input  logic [31:0]                  fx1_significand_se [NUM_VECTOR_LANES],
  input  logic [5:0]                   fx1_se_align_shift [NUM_VECTOR_LANES],
  input  logic [5:0]                   fx1_ftoi_lshift    [NUM_VECTOR_LANES],
  input  logic [7:0]                   fx1_add_exponent   [NUM_VECTOR_LANES],
  input  logic [NUM_VECTOR_LANES-1:0]  fx1_logical_subtract,
  input  logic [NUM_VECTOR_LANES-1:0]  fx1_add_result_sign,
  input  logic [31:0]                  fx1_multiplicand   [NUM_VECTOR_LANES],
  input  logic [31:0]                  fx1_multiplier     [NUM_VECTOR_LANES],
  input  logic [7:0]                   fx1_mul_exponent   [NUM_VECTOR_LANES],
  input  logic [NUM_VECTOR_LANES-1:0]  fx1_mul_sign,
  output logic                         fx2_instruction_valid,
  output decoded_instruction_t         fx2_instruction,
  output logic [NUM_VECTOR_LANES-1:0]  fx2_mask_value,
  output thread_idx_t                  fx2_thread_idx,
  output subcycle_t                    fx2_subcycle,
  output logic [NUM_VECTOR_LANES-1:0]  fx2_result_is_inf,
  output logic [NUM_VECTOR_LANES-1:0]  fx2_result_is_nan,
  output logic [31:0]                  fx2_significand_le [NUM_VECTOR_LANES],
  output logic [31:0]                  fx2_significand_se [NUM_VECTOR_LANES],
  output logic [NUM_VECTOR_LANES-1:0]  fx2_guard,
  output logic [NUM_VECTOR_LANES-1:0]  fx2_round,
  output logic [NUM_VECTOR_LANES-1:0]  fx2_sticky,
  output logic [7:0]                   fx2_add_exponent [NUM_VECTOR_LANES],
  output logic [NUM_VECTOR_LANES-1:0]  fx2_logical_subtract,
  output logic [NUM_VECTOR_LANES-1:0]  fx2_add_result_sign,
  output logic [63:0]                  fx2_significand_product [NUM_VECTOR_LANES],
  output logic [7:0]                   fx2_mul_exponent [NUM_VECTOR_LANES],
  output logic [NUM_VECTOR_LANES-1:0]  fx2_mul_sign
);

  // Flow is valid-only: an instruction is accepted whenever fx1_instruction_valid
  // is high and there is no ready, because this stage never stalls.
  logic                        squash;
  logic                        valid_d, valid_q;
  logic                        is_ftoi, is_mulh;
  logic [63:0]                 align_ext [NUM_VECTOR_LANES];
  logic [31:0]                 ftoi_val  [NUM_VECTOR_LANES];
  logic [31:0]                 se_d      [NUM_VECTOR_LANES];
  logic [31:0]                 se_q      [NUM_VECTOR_LANES];
  logic [63:0]                 product_d [NUM_VECTOR_LANES];
  logic [63:0]                 product_q [NUM_VECTOR_LANES];
  logic [NUM_VECTOR_LANES-1:0] guard_d, round_d, sticky_d;
  logic [NUM_VECTOR_LANES-1:0] guard_q, round_q, sticky_q;

  assign squash = wb_rollback_en && (wb_rollback_thread_idx == fx1_thread_idx)
                  && (wb_rollback_pipeline == PIPE_MEM);
  assign is_ftoi = (fx1_instruction.alu_op == OP_FTOI);
  assign is_mulh = (fx1_instruction.alu_op == OP_MULH_I);

  always_comb begin
    valid_d  = fx1_instruction_valid && !squash;
    guard_d  = '0;
    round_d  = '0;
    sticky_d = '0;
    for (int i = 0; i < NUM_VECTOR_LANES; i++) begin
      // Shifts of 32..63 stay inside the 64-bit window, so bits shifted past the
      // significand still land in guard/round/sticky.
      align_ext[i] = {fx1_significand_se[i], 32'h0} >> fx1_se_align_shift[i];
      ftoi_val[i]  = '0;
      if (fx1_se_align_shift[i] < 6'd32 && fx1_ftoi_lshift[i] < 6'd32)
        ftoi_val[i] = (fx1_significand_se[i] >> fx1_se_align_shift[i]) << fx1_ftoi_lshift[i];

      if (is_ftoi) begin
        se_d[i] = ftoi_val[i];
      end else begin
        se_d[i]     = align_ext[i][63:32];
        guard_d[i]  = align_ext[i][31];
        round_d[i]  = align_ext[i][30];
        sticky_d[i] = |align_ext[i][29:0];
      end

      if (is_mulh)
        product_d[i] = $signed({{32{fx1_multiplicand[i][31]}}, fx1_multiplicand[i]})
                     * $signed({{32{fx1_multiplier[i][31]}}, fx1_multiplier[i]});
      else
        product_d[i] = {32'h0, fx1_multiplicand[i]} * {32'h0, fx1_multiplier[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // Data registers have no reset; they are only meaningful alongside valid.
  always_ff @(posedge clk) begin
    se_q                 <= se_d;
    product_q            <= product_d;
    guard_q              <= guard_d;
    round_q              <= round_d;
    sticky_q             <= sticky_d;
    fx2_instruction      <= fx1_instruction;
    fx2_mask_value       <= fx1_mask_value;
    fx2_thread_idx       <= fx1_thread_idx;
    fx2_subcycle         <= fx1_subcycle;
    fx2_result_is_inf    <= fx1_result_is_inf;
    fx2_result_is_nan    <= fx1_result_is_nan;
    fx2_significand_le   <= fx1_significand_le;
    fx2_add_exponent     <= fx1_add_exponent;
    fx2_logical_subtract <= fx1_logical_subtract;
    fx2_add_result_sign  <= fx1_add_result_sign;
    fx2_mul_exponent     <= fx1_mul_exponent;
    fx2_mul_sign         <= fx1_mul_sign;
  end

  assign fx2_instruction_valid   = valid_q;
  assign fx2_significand_se      = se_q;
  assign fx2_significand_product = product_q;
  assign fx2_guard               = guard_q;
  assign fx2_round               = round_q;
  assign fx2_sticky              = sticky_q;

endmodule

// File: tb/tb_fp_execute_stage2.sv
// Directed bench for fp_execute_stage2: alignment, ftoi, multiply, rollback squash
// and asynchronous reset, each against hand-computed values.

module tb_fp_execute_stage2;
  import fp_defines_pkg::*;

  localparam int L = NUM_VECTOR_LANES;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 wb_rollback_en;
  thread_idx_t          wb_rollback_thread_idx;
  pipeline_sel_t        wb_rollback_pipeline;
  logic                 fx1_instruction_valid;
  decoded_instruction_t fx1_instruction;
  logic [L-1:0]         fx1_mask_value;
  thread_idx_t          fx1_thread_idx;
  subcycle_t            fx1_subcycle;
  logic [L-1:0]         fx1_result_is_inf, fx1_result_is_nan;
  logic [31:0]          fx1_significand_le [L];
  logic [31:0]          fx1_significand_se [L];
  logic [5:0]           fx1_se_align_shift [L];
  logic [5:0]           fx1_ftoi_lshift    [L];
  logic [7:0]           fx1_add_exponent   [L];
  logic [L-1:0]         fx1_logical_subtract, fx1_add_result_sign;
  logic [31:0]          fx1_multiplicand   [L];
  logic [31:0]          fx1_multiplier     [L];
  logic [7:0]           fx1_mul_exponent   [L];
  logic [L-1:0]         fx1_mul_sign;

  logic                 fx2_instruction_valid;
  decoded_instruction_t fx2_instruction;
  logic [L-1:0]         fx2_mask_value;
  thread_idx_t          fx2_thread_idx;
  subcycle_t            fx2_subcycle;
  logic [L-1:0]         fx2_result_is_inf, fx2_result_is_nan;
  logic [31:0]          fx2_significand_le [L];
  logic [31:0]          fx2_significand_se [L];
  logic [L-1:0]         fx2_guard, fx2_round, fx2_sticky;
  logic [7:0]           fx2_add_exponent [L];
  logic [L-1:0]         fx2_logical_subtract, fx2_add_result_sign;
  logic [63:0]          fx2_significand_product [L];
  logic [7:0]           fx2_mul_exponent [L];
  logic [L-1:0]         fx2_mul_sign;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [63:0] exp_q[$];

  fp_execute_stage2 dut (
    .clk                     (clk),
    .reset                   (reset),
    .wb_rollback_en          (wb_rollback_en),
    .wb_rollback_thread_idx  (wb_rollback_thread_idx),
    .wb_rollback_pipeline    (wb_rollback_pipeline),
    .fx1_instruction_valid   (fx1_instruction_valid),
    .fx1_instruction         (fx1_instruction),
    .fx1_mask_value          (fx1_mask_value),
    .fx1_thread_idx          (fx1_thread_idx),
    .fx1_subcycle            (fx1_subcycle),
    .fx1_result_is_inf       (fx1_result_is_inf),
    .fx1_result_is_nan       (fx1_result_is_nan),
    .fx1_significand_le      (fx1_significand_le),
    .fx1_significand_se      (fx1_significand_se),
    .fx1_se_align_shift      (fx1_se_align_shift),
    .fx1_ftoi_lshift         (fx1_ftoi_lshift),
    .fx1_add_exponent        (fx1_add_exponent),
    .fx1_logical_subtract    (fx1_logical_subtract),
    .fx1_add_result_sign     (fx1_add_result_sign),
    .fx1_multiplicand        (fx1_multiplicand),
    .fx1_multiplier          (fx1_multiplier),
    .fx1_mul_exponent        (fx1_mul_exponent),
    .fx1_mul_sign            (fx1_mul_sign),
    .fx2_instruction_valid   (fx2_instruction_valid),
    .fx2_instruction         (fx2_instruction),
    .fx2_mask_value          (fx2_mask_value),
    .fx2_thread_idx          (fx2_thread_idx),
    .fx2_subcycle            (fx2_subcycle),
    .fx2_result_is_inf       (fx2_result_is_inf),
    .fx2_result_is_nan       (fx2_result_is_nan),
    .fx2_significand_le      (fx2_significand_le),
    .fx2_significand_se      (fx2_significand_se),
    .fx2_guard               (fx2_guard),
    .fx2_round               (fx2_round),
    .fx2_sticky              (fx2_sticky),
    .fx2_add_exponent        (fx2_add_exponent),
    .fx2_logical_subtract    (fx2_logical_subtract),
    .fx2_add_result_sign     (fx2_add_result_sign),
    .fx2_significand_product (fx2_significand_product),
    .fx2_mul_exponent        (fx2_mul_exponent),
    .fx2_mul_sign            (fx2_mul_sign)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    wb_rollback_en         = 1'b0;
    wb_rollback_thread_idx = '0;
    wb_rollback_pipeline   = PIPE_INT_ARITH;
    fx1_instruction_valid  = 1'b0;
    fx1_instruction        = '{alu_op: OP_ADD_F, has_dest: 1'b1, dest_reg: 5'd0, dest_is_vector: 1'b1};
    fx1_mask_value         = '0;
    fx1_thread_idx         = '0;
    fx1_subcycle           = '0;
    fx1_result_is_inf      = '0;
    fx1_result_is_nan      = '0;
    fx1_logical_subtract   = '0;
    fx1_add_result_sign    = '0;
    fx1_mul_sign           = '0;
    for (int i = 0; i < L; i++) begin
      fx1_significand_le[i] = '0;
      fx1_significand_se[i] = '0;
      fx1_se_align_shift[i] = '0;
      fx1_ftoi_lshift[i]    = '0;
      fx1_add_exponent[i]   = '0;
      fx1_multiplicand[i]   = '0;
      fx1_multiplier[i]     = '0;
      fx1_mul_exponent[i]   = '0;
    end
  endtask

  task automatic set_op(input alu_op_t op);
    fx1_instruction.alu_op = op;
  endtask

  task automatic set_se(input int lane, input logic [31:0] se, input logic [5:0] rs,
                        input logic [5:0] ls);
    fx1_significand_se[lane] = se;
    fx1_se_align_shift[lane] = rs;
    fx1_ftoi_lshift[lane]    = ls;
  endtask

  task automatic set_mul(input int lane, input logic [31:0] a, input logic [31:0] b);
    fx1_multiplicand[lane] = a;
    fx1_multiplier[lane]   = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grs(input string tag, input int lane, input logic [2:0] exp);
    check(tag, {fx2_guard[lane], fx2_round[lane], fx2_sticky[lane]}, exp);
  endtask

  task automatic rollback_case(input string tag, input thread_idx_t t, input logic en,
                               input thread_idx_t rt, input pipeline_sel_t rp,
                               input logic exp_valid);
    fx1_instruction_valid  = 1'b1;
    fx1_thread_idx         = t;
    wb_rollback_en         = en;
    wb_rollback_thread_idx = rt;
    wb_rollback_pipeline   = rp;
    step();
    check(tag, fx2_instruction_valid, exp_valid);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #3;
    check("reset_valid", fx2_instruction_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Alignment and pass-through fields
    fx1_instruction_valid = 1'b1;
    set_op(OP_ADD_F);
    fx1_mask_value        = 16'hA5A5;
    fx1_subcycle          = 4'h3;
    fx1_significand_le[0] = 32'hDEADBEEF;
    fx1_add_exponent[0]   = 8'h7F;
    fx1_mul_sign          = 16'h8001;
    set_se(0, 32'h00800000, 6'd3, 6'd0);
    set_se(5, 32'h00800007, 6'd3, 6'd0);
    set_se(7, 32'h00FFFFFF, 6'd27, 6'd0);
    set_se(8, 32'hFFFFFFFF, 6'd40, 6'd0);
    set_se(9, 32'hC0000001, 6'd32, 6'd0);
    step();
    check("align_valid", fx2_instruction_valid, 1);
    check("align_nl_se", fx2_significand_se[0], 64'h00100000);
    check_grs("align_nl_grs", 0, 3'b000);
    check("align_loss_se", fx2_significand_se[5], 64'h00100000);
    check_grs("align_loss_grs", 5, 3'b111);
    check("align27_se", fx2_significand_se[7], 0);
    check_grs("align27_grs", 7, 3'b001);
    check("align40_se", fx2_significand_se[8], 0);
    check_grs("align40_grs", 8, 3'b001);
    check("align32_se", fx2_significand_se[9], 0);
    check_grs("align32_grs", 9, 3'b111);
    check("pass_le", fx2_significand_le[0], 64'hDEADBEEF);
    check("pass_addexp", fx2_add_exponent[0], 64'h7F);
    check("pass_mask", fx2_mask_value, 64'hA5A5);
    check("pass_subcycle", fx2_subcycle, 64'h3);
    check("pass_mulsign", fx2_mul_sign, 64'h8001);

    // Float-to-int truncate / shift
    set_op(OP_FTOI);
    set_se(0, 32'h00C00000, 6'd23, 6'd0);
    set_se(1, 32'h00800000, 6'd0, 6'd8);
    set_se(2, 32'h00800000, 6'd32, 6'd0);
    set_se(3, 32'h00000001, 6'd0, 6'd32);
    step();
    check("ftoi_r23_se", fx2_significand_se[0], 64'h1);
    check_grs("ftoi_r23_grs", 0, 3'b000);
    check("ftoi_l8_se", fx2_significand_se[1], 64'h80000000);
    check_grs("ftoi_l8_grs", 1, 3'b000);
    check("ftoi_r32_se", fx2_significand_se[2], 0);
    check_grs("ftoi_r32_grs", 2, 3'b000);
    check("ftoi_l32_se", fx2_significand_se[3], 0);
    check("ftoi_instr_op", fx2_instruction.alu_op, OP_FTOI);

    // Int-to-float passes the significand unshifted
    set_op(OP_ITOF);
    set_se(4, 32'h12345678, 6'd0, 6'd0);
    step();
    check("itof_se", fx2_significand_se[4], 64'h12345678);
    check_grs("itof_grs", 4, 3'b000);

    // Multiplies
    set_op(OP_MULL_I);
    set_mul(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    set_mul(1, 32'hFFFFFFFE, 32'h00000003);
    step();
    check("mull_ff", fx2_significand_product[0], 64'hFFFFFFFE00000001);
    check("mull_m2x3", fx2_significand_product[1], 64'h00000002FFFFFFFA);
    set_op(OP_MULH_I);
    step();
    check("mulh_ff", fx2_significand_product[0], 64'h0000000000000001);
    check("mulh_m2x3", fx2_significand_product[1], 64'hFFFFFFFFFFFFFFFA);
    set_op(OP_MUL_F);
    set_mul(2, 32'h00800000, 32'h00800000);
    step();
    check("mulf", fx2_significand_product[2], 64'h0000400000000000);

    // Rollback squash
    set_op(OP_ADD_F);
    rollback_case("rb_match",      2'd2, 1'b1, 2'd2, PIPE_MEM,         1'b0);
    rollback_case("rb_other_thr",  2'd1, 1'b1, 2'd2, PIPE_MEM,         1'b1);
    rollback_case("rb_other_pipe", 2'd2, 1'b1, 2'd2, PIPE_FLOAT_ARITH, 1'b1);
    rollback_case("rb_disabled",   2'd2, 1'b0, 2'd2, PIPE_MEM,         1'b1);
    wb_rollback_en = 1'b0;
    fx1_instruction_valid = 1'b0;
    step();
    check("invalid_in", fx2_instruction_valid, 0);

    // Back-to-back valid instructions
    fx1_instruction_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      fx1_thread_idx = thread_idx_t'(t);
      exp_q.push_back(64'(t));
      step();
      check("b2b_valid", fx2_instruction_valid, 1);
      check("b2b_thread", fx2_thread_idx, exp_q.pop_front());
    end

    // Asynchronous reset mid-stream
    fx1_thread_idx = 2'd1;
    step();
    check("pre_reset_valid", fx2_instruction_valid, 1);
    #2 reset = 1'b1;
    #1 check("async_reset_valid", fx2_instruction_valid, 0);
    step();
    check("held_reset_valid", fx2_instruction_valid, 0);
    reset = 1'b0;
    fx1_thread_idx = 2'd3;
    #1 check("post_reset_noedge", fx2_instruction_valid, 0);
    step();
    check("post_reset_valid", fx2_instruction_valid, 1);
    check("post_reset_thread", fx2_thread_idx, 64'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
